uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Downstream neighbour of the ASCII result encoder in the UART calculator datapath. It accepts encoded ASCII bytes on a byte/valid strobe and buffers them in a FIFO. It serialises each byte as a UART 8N1 frame on the tx line. Bit timing comes from the shared baud-enable pulse (txen) produced by gen_en.

Parameters:
DEPTH, 16, FIFO entries; must be a power of 2, minimum 2
AW, 4, address width, equal to log2(DEPTH)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
in_data  input  8  byte to transmit, typically ASCII from the encoder
in_valid  input  1  one-cycle write strobe for in_data
txen  input  1  baud tick, one clk cycle wide, once per bit period
clr_ovf  input  1  synchronous clear of the overflow flag
tx  output  1  UART serial line, idle high
tx_busy  output  1  high while a frame is being shifted (state is not IDLE)
fifo_count  output  AW+1  number of bytes currently stored
fifo_full  output  1  fifo_count == DEPTH
overflow  output  1  sticky flag: a write was dropped

Behaviour:
- Reset (async, rst=1): tx=1, tx_busy=0, fifo_count=0, fifo_full=0, overflow=0, state=IDLE, read/write pointers=0, bit counter=0.
- FIFO write: on a clk edge with in_valid=1, the byte is stored if (!fifo_full || pop this cycle). Pointers wrap modulo DEPTH.
- If in_valid=1 while full and no pop in that cycle: the byte is dropped, overflow<=1, contents are unchanged.
- clr_ovf=1 clears overflow. A drop in the same cycle wins, so overflow ends up set.
- No bypass path: a pop requires fifo_count!=0 before the edge. A byte written in cycle N is poppable from cycle N+1.
- Simultaneous push and pop: fifo_count is unchanged.
- All outputs are registered. fifo_count and fifo_full reflect the post-edge state.
- TX state machine. All transitions happen only on cycles with txen=1; otherwise the state, tx and the shift register hold.
  - IDLE: tx=1. If txen=1 and fifo_count!=0: pop the head into the shift register, tx<=0, go to START.
  - START: on txen, tx<=shift[0], bit_cnt<=0, go to DATA.
  - DATA: on txen, if bit_cnt==7: tx<=1, go to STOP. Otherwise tx<=shift[bit_cnt+1] and bit_cnt increments. Bits are sent LSB first.
  - STOP: on txen, if fifo_count!=0: pop, tx<=0, go to START (back-to-back frames, no extra idle bit). Otherwise go to IDLE with tx remaining 1.
- Frame timing: each bit lasts exactly one txen period. A full frame is 10 periods: start, 8 data bits, stop.
- Latency: the start bit is driven at the first txen edge after the byte is resident in the FIFO.
- tx_busy=1 in START, DATA and STOP; 0 in IDLE.
- in_valid during an active frame only affects the FIFO, never the frame in progress.
- A pending write and a pop may coincide at any state transition and both must take effect.
- Reset mid-frame: tx returns to 1 immediately (asynchronously), the FIFO is emptied and the partial frame is abandoned.
- Pointer arithmetic is AW bits with natural wrap. fifo_count is AW+1 bits, so it can represent DEPTH.

Test Plan:
- Single byte: write 0x35 with txen every 16 clk -> tx sequence over consecutive txen periods is 0,1,0,1,0,1,1,0,0,1. Then tx stays 1, tx_busy=0 and fifo_count=0.
- Encoder burst: 8 back-to-back writes "0000beef" (0x30,0x30,0x30,0x30,0x62,0x65,0x65,0x66) -> fifo_count peaks at 7 or 8. Exactly 80 txen periods with no idle-high gaps between stop and start bits. Decoded bytes match in order.
- Overflow: txen held 0, 17 writes 0x00..0x10 -> fifo_count=16, fifo_full=1, overflow=1. Then enable txen -> bytes 0x00..0x0F are sent and 0x10 never appears. clr_ovf pulse -> overflow=0.
- Full with simultaneous pop: fill to 16, then assert in_valid exactly on the cycle STOP pops -> the write is accepted, fifo_count stays 16, overflow stays 0.
- Reset mid-frame: assert rst during data bit 3 of 0xA5 -> tx=1 the same cycle, fifo_count=0, tx_busy=0. After release, tx stays idle with no residual frame.
- Sparse txen: txen pulses 50 clk apart with in_valid arriving in a non-txen cycle -> the start bit begins at the next txen edge and every bit lasts exactly 50 clk.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART 8N1 serialiser; bit timing comes from the shared txen tick.
// Back-to-back frames are chained from STOP straight into START when data is waiting.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          txen,
  input  logic          clr_ovf,
  output logic          tx,
  output logic          tx_busy,
  output logic [AW:0]   fifo_count,
  output logic          fifo_full,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic          tx_nxt;
  logic          pop, push, drop, empty;

  assign empty = (fifo_count == '0);

  // A pop frees a slot in the same edge, so a full FIFO still accepts a write then.
  assign push = in_valid && (!fifo_full || pop);
  assign drop = in_valid && fifo_full && !pop;
  assign count_nxt = fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_comb begin
    state_nxt   = state;
    tx_nxt      = tx;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    pop         = 1'b0;
    if (txen) begin
      case (state)
        IDLE: begin
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rptr];
            tx_nxt    = 1'b0;
            state_nxt = START;
          end
        end
        START: begin
          tx_nxt      = shift[0];
          bit_cnt_nxt = 3'd0;
          state_nxt   = DATA;
        end
        DATA: begin
          if (bit_cnt == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            tx_nxt      = shift[bit_cnt + 3'd1];
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
        STOP: begin
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rptr];
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: begin
          tx_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      shift   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tx      <= tx_nxt;
      tx_busy <= (state_nxt != IDLE);
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      fifo_count <= count_nxt;
      fifo_full  <= (count_nxt == FULL_CNT);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic against a
// queue-based model that tracks each frame as a bit index 0..9 per txen period.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          txen = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          tx, tx_busy, fifo_full, overflow;
  logic [AW:0]   fifo_count;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .txen(txen),
    .clr_ovf(clr_ovf), .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int per   = 0;
  int pcnt  = 0;
  int peak  = 0;

  logic [7:0] q[$];
  int         phase = -1;
  logic [7:0] cur = '0;
  logic       m_tx = 1'b1;
  logic       m_ovf = 1'b0;
  logic       tx_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_per(input int p);
    per  = p;
    pcnt = 0;
  endtask

  task automatic model_reset();
    q.delete();
    phase = -1;
    m_tx  = 1'b1;
    m_ovf = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic c);
    logic m_pop, m_push;
    in_valid = v;
    in_data  = d;
    clr_ovf  = c;
    txen     = (per != 0) && (pcnt == per - 1);
    if (per != 0) pcnt = (pcnt + 1) % per;
    m_pop  = txen && (phase < 0 || phase == 9) && (q.size() != 0);
    m_push = v && (q.size() < DEPTH || m_pop);
    if (v && !m_push) m_ovf = 1'b1;
    else if (c)       m_ovf = 1'b0;
    if (txen) begin
      if (phase < 0 || phase == 9) begin
        if (m_pop) begin
          cur   = q.pop_front();
          phase = 0;
          m_tx  = 1'b0;
        end else begin
          phase = -1;
          m_tx  = 1'b1;
        end
      end else begin
        phase++;
        m_tx = (phase <= 8) ? cur[phase-1] : 1'b1;
      end
    end
    if (m_push) q.push_back(d);
    @(posedge clk);
    #1;
    chk("tx", tx, m_tx);
    chk("tx_busy", tx_busy, phase >= 0);
    chk("fifo_count", fifo_count, q.size());
    chk("fifo_full", fifo_full, q.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    if (txen) tx_log.push_back(tx);
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    txen     = 1'b0;
  endtask

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 20000; i++) begin
      if (q.size() == 0 && phase < 0) break;
      cyc(1'b0, 8'h00, 1'b0);
    end
    if (i == 20000) chk({tag, "_drain_timeout"}, 1, 0);
  endtask

  initial begin
    logic exp_bits [10];
    logic [9:0] seq;
    logic found;

    #1 rst = 1'b1;
    #2;
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", overflow, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Single byte 0x35: expected line 0,1,0,1,0,1,1,0,0,1 (oldest first).
    seq = 10'b1001101010;
    for (int k = 0; k < 10; k++) exp_bits[k] = seq[k];
    set_per(16);
    tx_log.delete();
    cyc(1'b1, 8'h35, 1'b0);
    for (int i = 0; i < 16 * 12; i++) cyc(1'b0, 8'h00, 1'b0);
    found = (tx_log.size() >= 10);
    chk("single_len", found, 1);
    if (found)
      for (int k = 0; k < 10; k++) chk($sformatf("single_bit%0d", k), tx_log[k], exp_bits[k]);
    chk("single_idle_tx", tx, 1);
    chk("single_idle_busy", tx_busy, 0);
    chk("single_idle_count", fifo_count, 0);

    // Encoder burst "0000beef" back to back.
    set_per(4);
    peak = 0;
    foreach (seq[k]) begin end
    cyc(1'b1, 8'h30, 1'b0); cyc(1'b1, 8'h30, 1'b0);
    cyc(1'b1, 8'h30, 1'b0); cyc(1'b1, 8'h30, 1'b0);
    cyc(1'b1, 8'h62, 1'b0); cyc(1'b1, 8'h65, 1'b0);
    cyc(1'b1, 8'h65, 1'b0); cyc(1'b1, 8'h66, 1'b0);
    chk("burst_peak", (peak >= 7 && peak <= 8), 1);
    drain("burst");

    // Overflow: no txen, 17 writes.
    set_per(0);
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("ovf_count", fifo_count, 16);
    chk("ovf_full", fifo_full, 1);
    chk("ovf_flag", overflow, 1);
    set_per(4);
    drain("ovf");
    chk("ovf_sticky", overflow, 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("ovf_cleared", overflow, 0);

    // Full FIFO with a write landing on the STOP-state pop.
    set_per(0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom), 1'b0);
    set_per(3);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      found = (q.size() == 15);
    end
    chk("fullpop_first_pop", found, 1);
    cyc(1'b1, 8'hC3, 1'b0);
    chk("fullpop_refill", fifo_count, 16);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (pcnt == per - 1 && phase == 9) found = 1'b1;
      else cyc(1'b0, 8'h00, 1'b0);
    end
    chk("fullpop_reach_stop", found, 1);
    cyc(1'b1, 8'h3C, 1'b0);
    chk("fullpop_count", fifo_count, 16);
    chk("fullpop_full", fifo_full, 1);
    chk("fullpop_ovf", overflow, 0);
    drain("fullpop");

    // Reset during data bit 3 of 0xA5, with more bytes queued behind it.
    set_per(6);
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      found = (phase == 4);
    end
    chk("midrst_reach_bit3", found, 1);
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    #2;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", tx_busy, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_full", fifo_full, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    set_per(6);
    for (int i = 0; i < 80; i++) cyc(1'b0, 8'h00, 1'b0);

    // Sparse txen, write in a non-txen cycle.
    set_per(50);
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 50 * 12; i++) cyc(1'b0, 8'h00, 1'b0);
    chk("sparse_idle_tx", tx, 1);

    // Random traffic with varying baud periods and write rates.
    for (int s = 0; s < 10; s++) begin
      set_per($urandom_range(2, 12));
      for (int i = 0; i < 300; i++)
        cyc($urandom_range(0, 7) < (s % 4) + 1, 8'($urandom), $urandom_range(0, 40) == 0);
    end
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
